// File: rtl/lifo_stack_p.sv
// Parametrised LIFO stack with registered show-ahead top, occupancy count and boundary flags.
// Build option LIFO_STICKY_ERR_EN: when defined, ovf/unf latch until reset; otherwise they pulse for one cycle.
module lifo_stack_p #(
    parameter int WIDTH      = 11,
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      d,
    output logic [WIDTH-1:0]      top,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf,
    output logic                  unf
);

    localparam int                 DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] TWO_C   = (DEPTH_LOG2+1)'(2);
    localparam logic [DEPTH_LOG2:0] FULL_C  = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];

    logic [WIDTH-1:0]      top_q,   top_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, full_q;
    logic                  ovf_q,   ovf_d;
    logic                  unf_q,   unf_d;
    logic                  ovf_ev_s, unf_ev_s;
    logic                  wr_en_s;
    logic [DEPTH_LOG2-1:0] wr_idx_s;
    logic [DEPTH_LOG2:0]   count_m1_s, count_m2_s;

    assign count_m1_s = count_q - ONE_C;
    assign count_m2_s = count_q - TWO_C;

    // Next-state decode of the push/pop request pair
    always_comb begin
        count_d  = count_q;
        top_d    = top_q;
        wr_en_s  = 1'b0;
        wr_idx_s = '0;
        ovf_ev_s = 1'b0;
        unf_ev_s = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (full_q) begin
                    ovf_ev_s = 1'b1;
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = count_q[DEPTH_LOG2-1:0];
                    top_d    = d;
                    count_d  = count_q + ONE_C;
                end
            end
            2'b01: begin
                if (empty_q) begin
                    unf_ev_s = 1'b1;
                end else if (count_q == ONE_C) begin
                    count_d = '0;
                    top_d   = '0;
                end else begin
                    count_d = count_m1_s;
                    top_d   = mem[count_m2_s[DEPTH_LOG2-1:0]];
                end
            end
            2'b11: begin
                // An empty stack treats push+pop as a plain push; otherwise overwrite the top entry
                wr_en_s = 1'b1;
                top_d   = d;
                if (empty_q) begin
                    wr_idx_s = '0;
                    count_d  = ONE_C;
                end else begin
                    wr_idx_s = count_m1_s[DEPTH_LOG2-1:0];
                    count_d  = count_q;
                end
            end
            default: begin
                count_d = count_q;
                top_d   = top_q;
            end
        endcase
    end

    // Error flag next-state: sticky or single-cycle pulse depending on build
    always_comb begin
`ifdef LIFO_STICKY_ERR_EN
        ovf_d = ovf_q | ovf_ev_s;
        unf_d = unf_q | unf_ev_s;
`else
        ovf_d = ovf_ev_s;
        unf_d = unf_ev_s;
`endif
    end

    // Control and output registers; flags follow the next count so they never lag it
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            top_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_C);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents survive reset, only the write is suppressed
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            mem[wr_idx_s] <= d;
        end else begin
            mem[wr_idx_s] <= mem[wr_idx_s];
        end
    end

    assign top   = top_q;
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_lifo_stack_p.sv
// Directed self-checking bench for lifo_stack_p at WIDTH=11, DEPTH_LOG2=2.
// Expectations for ovf/unf after the offending cycle follow LIFO_STICKY_ERR_EN.
module tb_lifo_stack_p;

`ifdef LIFO_STICKY_ERR_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic [10:0] d;
    logic [10:0] top;
    logic [2:0]  count;
    logic        empty, full, ovf, unf;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          r;
        bit          pu;
        bit          po;
        logic [10:0] dd;
        logic [17:0] e;
    } step_t;

    lifo_stack_p #(.WIDTH(11), .DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .d     (d),
        .top   (top),
        .count (count),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {top, count, empty, full, ovf, unf};

    function automatic logic [17:0] mk(input logic [10:0] t, input logic [2:0] c,
                                       input bit em, input bit fu, input bit ov, input bit un);
        return {t, c, em, fu, ov, un};
    endfunction

    function automatic step_t st(input bit r, input bit pu, input bit po,
                                 input logic [10:0] dd, input logic [17:0] e);
        step_t s;
        s.r = r; s.pu = pu; s.po = po; s.dd = dd; s.e = e;
        return s;
    endfunction

    // Apply one cycle of stimulus; outputs are settled 1 time unit after the edge
    task automatic cycle(input bit r, input bit pu, input bit po, input logic [10:0] dd);
        reset = r; push = pu; pop = po; d = dd;
        @(posedge clk);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 11'h7FF);
        checks++;
        if (obs !== mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", obs, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_fill_and_drain();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h101, mk(11'h101, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h202, mk(11'h202, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h303, mk(11'h303, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h404, mk(11'h404, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h505, mk(11'h404, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h303, 3'd3, 1'b0, 1'b0, ST,   1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h202, 3'd2, 1'b0, 1'b0, ST,   1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h101, 3'd1, 1'b0, 1'b0, ST,   1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, ST,   1'b0)));
        foreach (s[i]) begin
            cycle(s[i].r, s[i].pu, s[i].po, s[i].dd);
            checks++;
            if (obs !== s[i].e) begin
                errors++;
                $display("FAIL fill_drain step %0d got %h expected %h", i, obs, s[i].e);
            end
        end
    endtask

    task automatic test_underflow();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1)));
        s.push_back(st(1'b0, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, ST)));
        s.push_back(st(1'b0, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, ST)));
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        foreach (s[i]) begin
            cycle(s[i].r, s[i].pu, s[i].po, s[i].dd);
            checks++;
            if (obs !== s[i].e) begin
                errors++;
                $display("FAIL underflow step %0d got %h expected %h", i, obs, s[i].e);
            end
        end
    endtask

    task automatic test_replace_top();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h101, mk(11'h101, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h202, mk(11'h202, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b1, 11'h7FF, mk(11'h7FF, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h101, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        foreach (s[i]) begin
            cycle(s[i].r, s[i].pu, s[i].po, s[i].dd);
            checks++;
            if (obs !== s[i].e) begin
                errors++;
                $display("FAIL replace_top step %0d got %h expected %h", i, obs, s[i].e);
            end
        end
    endtask

    task automatic test_boundaries();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b1, 11'h055, mk(11'h055, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h0A1, mk(11'h0A1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h0A2, mk(11'h0A2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h0A3, mk(11'h0A3, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b1, 11'h3AA, mk(11'h3AA, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h0A2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h0A1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h055, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        foreach (s[i]) begin
            cycle(s[i].r, s[i].pu, s[i].po, s[i].dd);
            checks++;
            if (obs !== s[i].e) begin
                errors++;
                $display("FAIL boundaries step %0d got %h expected %h", i, obs, s[i].e);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h111, mk(11'h111, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h222, mk(11'h222, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h111, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h333, mk(11'h333, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h111, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        foreach (s[i]) begin
            cycle(s[i].r, s[i].pu, s[i].po, s[i].dd);
            checks++;
            if (obs !== s[i].e) begin
                errors++;
                $display("FAIL back_to_back step %0d got %h expected %h", i, obs, s[i].e);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 11'h000, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h001, mk(11'h001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h002, mk(11'h002, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h003, mk(11'h003, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b1, 1'b1, 1'b0, 11'h123, mk(11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h456, mk(11'h456, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b1, 1'b0, 11'h789, mk(11'h789, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        s.push_back(st(1'b0, 1'b0, 1'b1, 11'h000, mk(11'h456, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        foreach (s[i]) begin
            cycle(s[i].r, s[i].pu, s[i].po, s[i].dd);
            checks++;
            if (obs !== s[i].e) begin
                errors++;
                $display("FAIL reset_mid step %0d got %h expected %h", i, obs, s[i].e);
            end
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; d = 11'h000;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_and_drain();
        test_underflow();
        test_replace_top();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo_stack_p.md
# lifo_stack_p

Parametrised LIFO stack with registered top-of-stack, occupancy count, full/empty flags and overflow/underflow detection. It replaces the fixed 11-bit/128-entry stack used by the expression-evaluation datapath. It adds simultaneous push/pop (replace-top), guarded boundaries and a show-ahead top output. It is single-clock and sits between the instruction decoder (push/pop requests) and the ALU operand path (top).

## Interface
- WIDTH, 11: data word width in bits.
- DEPTH_LOG2, 7: log2 of entry count; capacity = 2**DEPTH_LOG2 entries.
- clk  in  1  rising-edge clock.
- reset  in  1  reset: synchronous, active-high.
- push  in  1  push request, sampled at rising edge.
- pop  in  1  pop request, sampled at rising edge.
- d  in  WIDTH  data to push.
- top  out  WIDTH  registered top-of-stack value; 0 when empty.
- count  out  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2.
- empty  out  1  count == 0.
- full  out  1  count == 2**DEPTH_LOG2.
- ovf  out  1  overflow: push rejected because full.
- unf  out  1  underflow: pop rejected because empty.

## Operation
- Storage: register array mem[0..2**DEPTH_LOG2-1]; entry count-1 is the top. Memory contents are not cleared by reset.
- Reset, synchronous: count=0, top=0, empty=1, full=0, ovf=0, unf=0. Reset overrides push/pop in the same cycle.
- push only, not full: mem[count]<=d, top<=d, count<=count+1.
- push only, full: no state change; overflow event.
- pop only, count>=2: count<=count-1, top<=mem[count-2].
- pop only, count==1: count<=0, top<=0.
- pop only, empty: no state change; underflow event.
- push and pop, count>=1 (including full): replace-top. mem[count-1]<=d, top<=d, count unchanged, no error.
- push and pop, empty: behaves as push only. count<=1, top<=d, no error.
- Neither request: hold all state.
- empty/full are registered and derived from the next count value, so they are always consistent with count.
- Arithmetic: count is DEPTH_LOG2+1 bits wide and never wraps. The memory index uses the low DEPTH_LOG2 bits and only addresses valid entries.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency is 1 cycle. A request sampled at edge N is reflected in top/count/empty/full/ovf/unf after edge N.
- Back-to-back requests are accepted every cycle with no stall and no handshake beyond push/pop.
- A push followed immediately by a pop returns the pushed word to its prior state. top after the pop equals top before the push.
- Reset asserted mid-sequence empties the stack at that edge. The first push after reset deassertion lands in mem[0].

## Configuration
- LIFO_STICKY_ERR_EN defined: ovf/unf are sticky. Each is set by its event and held high until reset.
- LIFO_STICKY_ERR_EN undefined: ovf/unf are one-cycle pulses. Each is high only for the cycle following the offending edge and cleared on the next edge that has no new event.

## Test plan
- WIDTH=11, DEPTH_LOG2=2. Reset, then push 0x101, 0x202, 0x303 on consecutive cycles -> top=0x303, count=3, empty=0, full=0.
- From count=3, push 0x404, then push 0x505 -> after the first push full=1, count=4, top=0x404. After the second: count=4, top=0x404, ovf=1. Pop four times -> top sequence 0x303, 0x202, 0x101, 0; empty=1.
- Empty, pop -> unf=1, count=0, top=0. Sticky build: unf stays 1 until reset. Non-sticky build: unf returns to 0 after one idle cycle.
- Stack [0x101, 0x202], push+pop with d=0x7FF -> count=2, top=0x7FF. Then pop -> top=0x101, count=1.
- Empty, push+pop with d=0x055 -> count=1, top=0x055, unf=0, ovf=0. Full, push+pop with d=0x3AA -> count=4, top=0x3AA, ovf=0.
- Stack at count=3, assert reset with push=1, d=0x123 -> count=0, top=0, empty=1, ovf=0, unf=0. Next push 0x456 -> top=0x456, count=1.
